// File: rtl/macro_sequencer.sv
// macro_sequencer: expands CALL/RET/INT/RTI into PUSH/POP/JMP micro-ops,
// one per cycle, with an operand select for each. HLT freezes the
// sequencer, RESET pulses soft_rst, and all other opcodes pass through.
// Optional interrupt injection is enabled with `define MACRO_SEQ_IRQ_EN.
module macro_sequencer #(
   parameter int OPW      = 7,
   parameter int PC_WORDS = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           instr_valid,
   input  logic [OPW-1:0] instr_op,
   output logic           instr_ready,
   output logic           uop_valid,
   output logic [OPW-1:0] uop_op,
   output logic [2:0]     uop_sel,
   input  logic           uop_ready,
`ifdef MACRO_SEQ_IRQ_EN
   input  logic           irq,
   output logic           irq_ack,
`endif
   output logic           soft_rst,
   output logic           halted
);

   localparam logic [OPW-1:0] OP_NOP   = OPW'(7'b0000000);
   localparam logic [OPW-1:0] OP_HLT   = OPW'(7'b0000100);
   localparam logic [OPW-1:0] OP_RESET = OPW'(7'b0001000);
   localparam logic [OPW-1:0] OP_PUSH  = OPW'(7'b1000000);
   localparam logic [OPW-1:0] OP_POP   = OPW'(7'b1001000);
   localparam logic [OPW-1:0] OP_JMP   = OPW'(7'b1101100);
   localparam logic [OPW-1:0] OP_CALL  = OPW'(7'b1110000);
   localparam logic [OPW-1:0] OP_RET   = OPW'(7'b1110100);
   localparam logic [OPW-1:0] OP_INT   = OPW'(7'b1111000);
   localparam logic [OPW-1:0] OP_RTI   = OPW'(7'b1111100);

   localparam logic [2:0] SEL_REG   = 3'd0;
   localparam logic [2:0] SEL_PC_HI = 3'd1;
   localparam logic [2:0] SEL_PC_LO = 3'd2;
   localparam logic [2:0] SEL_FLAGS = 3'd3;
   localparam logic [2:0] SEL_VEC   = 3'd4;

   typedef enum logic [1:0] {ST_IDLE, ST_SEQ, ST_HALT} state_t;
   typedef enum logic [1:0] {MC_CALL, MC_RET, MC_INT, MC_RTI} macro_t;

   state_t      state_reg;
   macro_t      kind_reg;
   logic [1:0]  step_reg;

   logic           load_ok;
   logic           accept;
   logic           irq_take;
   logic           dec_macro;
   macro_t         dec_kind;
   macro_t         cur_kind;
   logic [1:0]     cur_step;
   logic [OPW+2:0] cur_entry;
   logic           cur_last;

   // Number of micro-ops in a macro; every macro carries exactly one PC_HI entry.
   function automatic logic [2:0] macro_len(input macro_t kind);
      logic [2:0] n;
      case (kind)
         MC_CALL: n = 3'd3;
         MC_RET:  n = 3'd2;
         MC_INT:  n = 3'd4;
         default: n = 3'd3;
      endcase
      return (PC_WORDS == 1) ? n - 3'd1 : n;
   endfunction

   // Table lookup {op, sel}; with one PC word the PC_HI entries are skipped.
   function automatic logic [OPW+2:0] macro_entry(input macro_t kind, input logic [1:0] step);
      logic [OPW+2:0] full [4];
      logic [2:0]     n;
      logic [2:0]     cnt;
      logic [OPW+2:0] res;
      res = {OP_NOP, SEL_REG};
      cnt = 3'd0;
      for (int i = 0; i < 4; i++) full[i] = {OP_NOP, SEL_REG};
      case (kind)
         MC_CALL: begin
            full[0] = {OP_PUSH, SEL_PC_HI}; full[1] = {OP_PUSH, SEL_PC_LO};
            full[2] = {OP_JMP, SEL_REG};    n = 3'd3;
         end
         MC_RET: begin
            full[0] = {OP_POP, SEL_PC_LO};  full[1] = {OP_POP, SEL_PC_HI};
            n = 3'd2;
         end
         MC_INT: begin
            full[0] = {OP_PUSH, SEL_FLAGS}; full[1] = {OP_PUSH, SEL_PC_HI};
            full[2] = {OP_PUSH, SEL_PC_LO}; full[3] = {OP_JMP, SEL_VEC};
            n = 3'd4;
         end
         default: begin
            full[0] = {OP_POP, SEL_PC_LO};  full[1] = {OP_POP, SEL_PC_HI};
            full[2] = {OP_POP, SEL_FLAGS};  n = 3'd3;
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         if (i < int'(n) && !(PC_WORDS == 1 && full[i][2:0] == SEL_PC_HI)) begin
            if (cnt == {1'b0, step}) res = full[i];
            cnt = cnt + 3'd1;
         end
      end
      return res;
   endfunction

   assign load_ok = !uop_valid || uop_ready;

`ifdef MACRO_SEQ_IRQ_EN
   assign irq_take = (state_reg == ST_IDLE) && load_ok && irq;
`else
   assign irq_take = 1'b0;
`endif

   assign instr_ready = (state_reg == ST_IDLE) && load_ok && !irq_take;
   assign accept      = instr_valid && instr_ready;

   // Decode the incoming opcode (or an injected interrupt) and select the table entry to load.
   always_comb begin
      dec_macro = 1'b0;
      dec_kind  = MC_CALL;
      if (irq_take) begin
         dec_macro = 1'b1;
         dec_kind  = MC_INT;
      end else begin
         case (instr_op)
            OP_CALL: begin dec_macro = 1'b1; dec_kind = MC_CALL; end
            OP_RET:  begin dec_macro = 1'b1; dec_kind = MC_RET;  end
            OP_INT:  begin dec_macro = 1'b1; dec_kind = MC_INT;  end
            OP_RTI:  begin dec_macro = 1'b1; dec_kind = MC_RTI;  end
            default: dec_macro = 1'b0;
         endcase
      end
      cur_kind  = (state_reg == ST_IDLE) ? dec_kind : kind_reg;
      cur_step  = (state_reg == ST_IDLE) ? 2'd0 : step_reg;
      cur_entry = macro_entry(cur_kind, cur_step);
      cur_last  = ({1'b0, cur_step} == macro_len(cur_kind) - 3'd1);
   end

   // Sequencer FSM with registered micro-op, soft_rst and halted outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         kind_reg  <= MC_CALL;
         step_reg  <= 2'd0;
         uop_valid <= 1'b0;
         uop_op    <= OP_NOP;
         uop_sel   <= SEL_REG;
         soft_rst  <= 1'b0;
         halted    <= 1'b0;
`ifdef MACRO_SEQ_IRQ_EN
         irq_ack   <= 1'b0;
`endif
      end else begin
         soft_rst <= 1'b0;
`ifdef MACRO_SEQ_IRQ_EN
         irq_ack  <= irq_take;
`endif
         case (state_reg)
            ST_IDLE: begin
               if (load_ok) begin
                  if ((irq_take || accept) && dec_macro) begin
                     uop_valid           <= 1'b1;
                     {uop_op, uop_sel}   <= cur_entry;
                     kind_reg            <= dec_kind;
                     if (!cur_last) begin
                        state_reg <= ST_SEQ;
                        step_reg  <= 2'd1;
                     end
                  end else if (accept) begin
                     uop_valid <= 1'b1;
                     uop_sel   <= SEL_REG;
                     if (instr_op == OP_HLT) begin
                        uop_op    <= OP_NOP;
                        state_reg <= ST_HALT;
                        halted    <= 1'b1;
                     end else if (instr_op == OP_RESET) begin
                        uop_op   <= OP_NOP;
                        soft_rst <= 1'b1;
                     end else begin
                        uop_op <= instr_op;
                     end
                  end else begin
                     uop_valid <= 1'b0;
                  end
               end
            end
            ST_SEQ: begin
               if (load_ok) begin
                  uop_valid         <= 1'b1;
                  {uop_op, uop_sel} <= cur_entry;
                  if (cur_last) begin
                     state_reg <= ST_IDLE;
                     step_reg  <= 2'd0;
                  end else begin
                     step_reg <= step_reg + 2'd1;
                  end
               end
            end
            default: begin
               if (uop_ready) uop_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_macro_sequencer.sv
// Self-checking bench for macro_sequencer: directed scenarios plus random
// traffic, compared every cycle against a queue-based reference model.
module tb_macro_sequencer;

   localparam int OPW = 7;
   localparam int PW  = 2;

   localparam logic [6:0] NOP = 7'b0000000, HLT = 7'b0000100, RSTOP = 7'b0001000;
   localparam logic [6:0] PUSH = 7'b1000000, POP = 7'b1001000, JMP = 7'b1101100;
   localparam logic [6:0] CALL = 7'b1110000, RET = 7'b1110100, INT = 7'b1111000, RTI = 7'b1111100;
   localparam logic [6:0] ADD = 7'b0100000;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           instr_valid = 1'b0;
   logic [OPW-1:0] instr_op = '0;
   logic           instr_ready;
   logic           uop_valid;
   logic [OPW-1:0] uop_op;
   logic [2:0]     uop_sel;
   logic           uop_ready = 1'b0;
   logic           soft_rst;
   logic           halted;
   logic           irq_r = 1'b0;
`ifdef MACRO_SEQ_IRQ_EN
   logic           irq_ack;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: output slot, ops still to be issued, flags
   logic        mv;
   logic [6:0]  mop;
   logic [2:0]  msel;
   logic        mhalt, msoft, mack;
   logic [9:0]  pend[$];

   macro_sequencer #(.OPW(OPW), .PC_WORDS(PW)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_op(instr_op), .instr_ready(instr_ready),
      .uop_valid(uop_valid), .uop_op(uop_op), .uop_sel(uop_sel), .uop_ready(uop_ready),
`ifdef MACRO_SEQ_IRQ_EN
      .irq(irq_r), .irq_ack(irq_ack),
`endif
      .soft_rst(soft_rst), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mv = 0; mop = NOP; msel = 0; mhalt = 0; msoft = 0; mack = 0;
      pend.delete();
   endtask

   // Micro-op list for an opcode, straight from the macro table.
   task automatic expand(input logic [6:0] op);
      case (op)
         CALL: begin
            if (PW == 2) pend.push_back({PUSH, 3'd1});
            pend.push_back({PUSH, 3'd2}); pend.push_back({JMP, 3'd0});
         end
         RET: begin
            pend.push_back({POP, 3'd2});
            if (PW == 2) pend.push_back({POP, 3'd1});
         end
         INT: begin
            pend.push_back({PUSH, 3'd3});
            if (PW == 2) pend.push_back({PUSH, 3'd1});
            pend.push_back({PUSH, 3'd2}); pend.push_back({JMP, 3'd4});
         end
         RTI: begin
            pend.push_back({POP, 3'd2});
            if (PW == 2) pend.push_back({POP, 3'd1});
            pend.push_back({POP, 3'd3});
         end
         HLT, RSTOP: pend.push_back({NOP, 3'd0});
         default:    pend.push_back({op, 3'd0});
      endcase
   endtask

   task automatic model_update(input logic iv, input logic [6:0] iop, input logic ur);
      logic lok;
      lok = !mv || ur;
      msoft = 0; mack = 0;
      if (mhalt) begin
         if (ur) mv = 0;
      end else if (pend.size() != 0) begin
         if (lok) begin {mop, msel} = pend.pop_front(); mv = 1; end
      end else if (lok) begin
         if (irq_r) begin
            expand(INT); {mop, msel} = pend.pop_front(); mv = 1; mack = 1;
         end else if (iv) begin
            expand(iop); {mop, msel} = pend.pop_front(); mv = 1;
            if (iop == HLT) mhalt = 1;
            if (iop == RSTOP) msoft = 1;
         end else begin
            mv = 0;
         end
      end
   endtask

   task automatic check_outputs(input string tag, input logic ur);
      logic exp_ready;
      exp_ready = !mhalt && (pend.size() == 0) && (!mv || ur) && !irq_r;
      chk({tag, ".instr_ready"}, 32'(instr_ready), 32'(exp_ready));
      chk({tag, ".uop_valid"}, 32'(uop_valid), 32'(mv));
      if (mv) begin
         chk({tag, ".uop_op"}, 32'(uop_op), 32'(mop));
         chk({tag, ".uop_sel"}, 32'(uop_sel), 32'(msel));
      end
      chk({tag, ".halted"}, 32'(halted), 32'(mhalt));
      chk({tag, ".soft_rst"}, 32'(soft_rst), 32'(msoft));
`ifdef MACRO_SEQ_IRQ_EN
      chk({tag, ".irq_ack"}, 32'(irq_ack), 32'(mack));
`endif
   endtask

   // One clock cycle: drive at negedge, check, let the edge happen, advance model.
   task automatic step_cycle(input logic iv, input logic [6:0] iop, input logic ur, input string tag);
      instr_valid = iv; instr_op = iop; uop_ready = ur;
      #1;
      check_outputs(tag, ur);
      $display("cycle %s iv=%0b op=%b ur=%0b -> uv=%0b uop=%b sel=%0d rdy=%0b", tag, iv, iop, ur,
               uop_valid, uop_op, uop_sel, instr_ready);
      @(posedge clk);
      model_update(iv, iop, ur);
      @(negedge clk);
   endtask

   task automatic rst_pulse(input string tag);
      instr_valid = 0; uop_ready = 1; rst = 1;
      #1;
      chk({tag, ".rst_uop_valid"}, 32'(uop_valid), 32'd0);
      chk({tag, ".rst_halted"}, 32'(halted), 32'd0);
      chk({tag, ".rst_soft"}, 32'(soft_rst), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
   endtask

   function automatic logic [6:0] pick_op();
      logic [6:0] r;
      case ($urandom_range(0, 7))
         0: r = CALL;
         1: r = RET;
         2: r = INT;
         3: r = RTI;
         4: r = RSTOP;
         default: begin
            r = 7'($urandom_range(0, 127));
            if (r == HLT) r = ADD;
         end
      endcase
      return r;
   endfunction

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      chk("reset.uop_valid", 32'(uop_valid), 32'd0);
      chk("reset.uop_op", 32'(uop_op), 32'd0);
      chk("reset.uop_sel", 32'(uop_sel), 32'd0);
      chk("reset.soft_rst", 32'(soft_rst), 32'd0);
      chk("reset.halted", 32'(halted), 32'd0);
      @(negedge clk);
      rst = 0;

      // pass-through ADD
      step_cycle(1, ADD, 1, "add0");
      step_cycle(0, NOP, 1, "add1");
      step_cycle(0, NOP, 1, "add2");

      // CALL with free-running downstream
      step_cycle(1, CALL, 1, "call0");
      for (int i = 1; i <= 4; i++) step_cycle(0, NOP, 1, $sformatf("call%0d", i));

      // INT with back-pressure at cycles 2-3
      step_cycle(1, INT, 1, "int0");
      step_cycle(0, NOP, 1, "int1");
      step_cycle(0, NOP, 0, "int2");
      step_cycle(0, NOP, 0, "int3");
      for (int i = 4; i <= 7; i++) step_cycle(0, NOP, 1, $sformatf("int%0d", i));

      // RESET opcode pulses soft_rst
      step_cycle(1, RSTOP, 1, "softrst0");
      step_cycle(0, NOP, 1, "softrst1");
      step_cycle(0, NOP, 1, "softrst2");

      // rst during RTI, then RET
      step_cycle(1, RTI, 1, "rti0");
      step_cycle(0, NOP, 1, "rti1");
      rst_pulse("rti_rst");
      step_cycle(1, RET, 1, "ret0");
      for (int i = 1; i <= 3; i++) step_cycle(0, NOP, 1, $sformatf("ret%0d", i));

`ifdef MACRO_SEQ_IRQ_EN
      // irq injection takes priority over an offered ADD
      irq_r = 1;
      step_cycle(1, ADD, 1, "irq0");
      irq_r = 0;
      for (int i = 1; i <= 6; i++) step_cycle(1, ADD, 1, $sformatf("irq%0d", i));
      step_cycle(0, NOP, 1, "irq7");
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         step_cycle(1'($urandom_range(0, 1)), pick_op(), ($urandom_range(0, 3) != 0),
                    $sformatf("rnd%0d", i));
      end
      for (int i = 0; i < 6; i++) step_cycle(0, NOP, 1, $sformatf("drain%0d", i));

      // HLT then NOPs offered for 20 cycles, then rst
      step_cycle(1, HLT, 1, "hlt0");
      for (int i = 1; i <= 20; i++) step_cycle(1, NOP, 1, $sformatf("hlt%0d", i));
      rst_pulse("hlt_rst");
      step_cycle(1, ADD, 1, "post0");
      step_cycle(0, NOP, 1, "post1");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
